entrada_senha: RTL and testbench
================================

Name: entrada_senha

Overview:
- Keypad entry stage directly upstream of the access controller.
- Collects N_DIGITS key codes from a keypad scanner into a shift buffer.
- On the confirm key, publishes the assembled code on senha_digitada with a one-cycle senha_valida strobe.
- Holds senha_digitada stable between confirmations so the downstream comparator sees a steady value. Also handles clear, incomplete entry and inactivity timeout.

Parameters:
DIGIT_W, 4, bits per key code
N_DIGITS, 2, digits per password; output width = DIGIT_W*N_DIGITS (8 at defaults)
TIMEOUT_CYC, 50000000, idle cycles in ENTRADA before automatic clear (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tecla  input  DIGIT_W  key code from scanner; valid while tecla_press high
tecla_press  input  1  level, high while a digit key is held
tecla_ok  input  1  level, high while confirm key is held
tecla_limpa  input  1  level, high while clear key is held
senha_digitada  output  DIGIT_W*N_DIGITS  last confirmed code, registered
senha_valida  output  1  one-cycle pulse when senha_digitada is updated
n_digitos  output  clog2(N_DIGITS+1)  digits currently buffered
erro_incompleto  output  1  one-cycle pulse: confirm with fewer than N_DIGITS digits
timeout  output  1  one-cycle pulse: entry abandoned by inactivity

Behaviour:
- Reset (rst_n low, async) values:
  - senha_digitada=0, senha_valida=0, n_digitos=0, erro_incompleto=0, timeout=0.
  - Buffer=0, idle counter=0, edge-detect registers=0, state=IDLE.
- Edge detection:
  - tecla_press, tecla_ok and tecla_limpa are registered once.
  - An event is the rising edge: current high, previous low.
  - Holding a key produces exactly one event.
  - tecla is sampled in the same cycle as the tecla_press event.
- Digit filter: codes above 9 are ignored (no shift, no count change, idle counter not reset).
- Event priority in one cycle: limpa > ok > digit. Lower-priority simultaneous events are discarded.
- States: IDLE, ENTRADA, CHEIO.
  - IDLE: a valid digit event shifts it in, sets n_digitos=1 and moves to ENTRADA.
  - ENTRADA: each digit event does buffer <= {buffer[upper-DIGIT_W-1:0], tecla} and n_digitos+1. When n_digitos reaches N_DIGITS, move to CHEIO.
  - CHEIO: further digit events are ignored (no overwrite, count saturated).
  - ok event in CHEIO:
    - Next edge: senha_digitada <= buffer and senha_valida=1 for exactly one cycle (latency 1 cycle from the registered event).
    - Buffer and n_digitos cleared; return to IDLE.
  - ok event in IDLE or ENTRADA:
    - erro_incompleto pulses one cycle; buffer and n_digitos cleared; state IDLE.
    - senha_digitada unchanged.
  - limpa event in any state: buffer and n_digitos cleared, state IDLE, no pulses.
- Idle counter:
  - Runs in ENTRADA and CHEIO; reset to 0 on every accepted digit event and on leaving those states.
  - When it reaches TIMEOUT_CYC-1: timeout pulses one cycle, buffer and n_digitos cleared, state IDLE.
  - If an event occurs in the same cycle as the timeout, the event is handled and the timeout is suppressed.
- senha_digitada changes only on a successful confirmation or reset.
- Pulse outputs are mutually exclusive and never high for more than one consecutive cycle.
- Reset asserted mid-entry discards all partial digits immediately.

Optional Feature:
- TIMEOUT_EN defined:
  - Idle counter and timeout output implemented as described.
- TIMEOUT_EN undefined:
  - No idle counter is synthesized; timeout is tied to 0.
  - Partial entry persists until limpa, ok or reset.
  - All other behaviour is identical.

Test Plan:
- Reset, then press 3 and 7 (each held 5 cycles), then ok -> senha_digitada=8'h37, senha_valida high exactly 1 cycle, n_digitos 0→1→2→0.
- Press 5, then ok -> erro_incompleto 1-cycle pulse, senha_digitada keeps previous 8'h37, n_digitos=0.
- Press 1, 2, 9, then ok -> third digit ignored, output 8'h12. Key code 4'hB pressed mid-entry -> no effect.
- Press 4, then limpa and ok in the same cycle -> clear wins, no pulse, n_digitos=0, output unchanged.
- With TIMEOUT_EN and TIMEOUT_CYC=20: press 6, then idle 19 cycles -> timeout pulse, n_digitos=0. Same with a digit at cycle 19 -> no timeout, n_digitos=2. Without TIMEOUT_EN -> no timeout, n_digitos stays 1 after 100 cycles.
- Assert rst_n low mid-entry (n_digitos=1, output 8'h12) -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/entrada_senha_if.sv
// entrada_senha_if: keypad-side inputs and confirmed-code outputs of the
// password entry stage. The master side is the keypad scanner and the
// downstream consumer; the slave side is the entry stage itself.
interface entrada_senha_if #(
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned N_DIGITS = 2
);
  localparam int unsigned CODE_W  = DIGIT_W * N_DIGITS;
  localparam int unsigned COUNT_W = $clog2(N_DIGITS + 1);

  logic [DIGIT_W-1:0] tecla;
  logic               tecla_press;
  logic               tecla_ok;
  logic               tecla_limpa;
  logic [CODE_W-1:0]  senha_digitada;
  logic               senha_valida;
  logic [COUNT_W-1:0] n_digitos;
  logic               erro_incompleto;
  logic               timeout;

  modport master (
    output tecla, tecla_press, tecla_ok, tecla_limpa,
    input  senha_digitada, senha_valida, n_digitos, erro_incompleto, timeout
  );

  modport slave (
    input  tecla, tecla_press, tecla_ok, tecla_limpa,
    output senha_digitada, senha_valida, n_digitos, erro_incompleto, timeout
  );
endinterface

// File: rtl/entrada_senha.sv
// entrada_senha: collects N_DIGITS decimal key codes, publishes the code on
// the confirm key and holds it until the next successful confirmation.
// Handles clear, incomplete entry and (optionally) inactivity timeout.
// Optional feature: define TIMEOUT_EN to build the idle counter and the
// timeout pulse; without it a partial entry waits for clear, confirm or reset.
module entrada_senha #(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned N_DIGITS    = 2,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  entrada_senha_if.slave bus
);
  localparam int unsigned CODE_W  = DIGIT_W * N_DIGITS;
  localparam int unsigned COUNT_W = $clog2(N_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, ENTRADA, CHEIO} state_t;

  state_t             state_q, state_next;
  logic [CODE_W-1:0]  buf_q, buf_next;
  logic [CODE_W-1:0]  senha_q, senha_next;
  logic [COUNT_W-1:0] n_q, n_next;
  logic               valida_q, valida_next;
  logic               erro_q, erro_next;
  logic               timeout_q, timeout_next;
  logic               press_q, ok_q, limpa_q;
  logic               press_ev, ok_ev, limpa_ev, digit_ev;
  logic               accept;
  logic               timeout_hit;

  // Rising-edge detection: a held key yields exactly one event.
  assign press_ev = bus.tecla_press & ~press_q;
  assign ok_ev    = bus.tecla_ok    & ~ok_q;
  assign limpa_ev = bus.tecla_limpa & ~limpa_q;
  // Only decimal key codes count as digits.
  assign digit_ev = press_ev && (32'(bus.tecla) <= 32'd9);

  // Next-state and output decode; priority is clear > confirm > digit > timeout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next   = state_q;
    buf_next     = buf_q;
    n_next       = n_q;
    senha_next   = senha_q;
    valida_next  = 1'b0;
    erro_next    = 1'b0;
    timeout_next = 1'b0;
    accept       = 1'b0;

    if (limpa_ev) begin
      state_next = IDLE;
      buf_next   = '0;
      n_next     = '0;
    end else if (ok_ev) begin
      if (state_q == CHEIO) begin
        senha_next  = buf_q;
        valida_next = 1'b1;
      end else begin
        erro_next = 1'b1;
      end
      state_next = IDLE;
      buf_next   = '0;
      n_next     = '0;
    end else if (digit_ev && state_q != CHEIO) begin
      accept     = 1'b1;
      buf_next   = (buf_q << DIGIT_W) | CODE_W'(bus.tecla);
      n_next     = n_q + 1'b1;
      state_next = (n_next == COUNT_W'(N_DIGITS)) ? CHEIO : ENTRADA;
    end else if (timeout_hit) begin
      timeout_next = 1'b1;
      state_next   = IDLE;
      buf_next     = '0;
      n_next       = '0;
    end
  end

  // State, buffer, edge-detect history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the digit buffer is reset too, so a partial entry can never
      // leak into a later code after reset.
      state_q   <= IDLE;
      buf_q     <= '0;
      n_q       <= '0;
      senha_q   <= '0;
      valida_q  <= 1'b0;
      erro_q    <= 1'b0;
      timeout_q <= 1'b0;
      press_q   <= 1'b0;
      ok_q      <= 1'b0;
      limpa_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_next;
      buf_q     <= buf_next;
      n_q       <= n_next;
      senha_q   <= senha_next;
      valida_q  <= valida_next;
      erro_q    <= erro_next;
      timeout_q <= timeout_next;
      press_q   <= bus.tecla_press;
      ok_q      <= bus.tecla_ok;
      limpa_q   <= bus.tecla_limpa;
    end
  end

`ifdef TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);

  logic [IDLE_W-1:0] idle_q, idle_next;

  // The counter would reach TIMEOUT_CYC-1 on this edge, so fire now.
  assign timeout_hit = (state_q != IDLE) && (idle_q == IDLE_W'(TIMEOUT_CYC - 2));

  // Idle counter: counts while an entry stays open, restarts on accepted digits.
  always_comb begin
    idle_next = '0;
    if (state_q != IDLE && state_next != IDLE && !accept) begin
      idle_next = idle_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_next;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 1);
`endif

  assign bus.senha_digitada  = senha_q;
  assign bus.senha_valida    = valida_q;
  assign bus.n_digitos       = n_q;
  assign bus.erro_incompleto = erro_q;
  assign bus.timeout         = timeout_q;
endmodule

// File: tb/tb_entrada_senha.sv
// tb_entrada_senha: table-driven and hand-sequenced checks of entrada_senha
// with a one-deep scoreboard of expected outputs per driven cycle.
module tb_entrada_senha;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned N_DIGITS    = 2;
  localparam int unsigned TIMEOUT_CYC = 20;

  typedef enum logic [1:0] {P_NONE, P_VAL, P_ERR, P_TO} pulse_t;

  typedef struct {
    string      name;
    logic [3:0] tecla;
    logic       press;
    logic       ok;
    logic       limpa;
    int         rep;
    logic [7:0] senha;
    logic [1:0] n;
    pulse_t     pulse;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] senha;
    logic [1:0] n;
    logic       valida;
    logic       erro;
    logic       to;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  localparam int NV = 30;
  vec_t vecs[NV];

  entrada_senha_if #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS)) bus ();

  entrada_senha #(
    .DIGIT_W    (DIGIT_W),
    .N_DIGITS   (N_DIGITS),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t required below 100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, ".senha"},  32'(bus.senha_digitada),  32'(e.senha));
      check({e.name, ".n"},      32'(bus.n_digitos),       32'(e.n));
      check({e.name, ".valida"}, 32'(bus.senha_valida),    32'(e.valida));
      check({e.name, ".erro"},   32'(bus.erro_incompleto), 32'(e.erro));
      check({e.name, ".to"},     32'(bus.timeout),         32'(e.to));
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs after the next edge.
  task automatic drive(input string name, input logic [3:0] k, input logic p, input logic o,
                       input logic l, input logic [7:0] es, input logic [1:0] en, input pulse_t ep);
    exp_t e;
    bus.tecla       = k;
    bus.tecla_press = p;
    bus.tecla_ok    = o;
    bus.tecla_limpa = l;
    e.name   = name;
    e.senha  = es;
    e.n      = en;
    e.valida = (ep == P_VAL);
    e.erro   = (ep == P_ERR);
    e.to     = (ep == P_TO);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //          name          key   prs   ok    lmp   rep senha  n     pulse
    vecs[0]  = '{"t1_press3", 4'h3, 1'b1, 1'b0, 1'b0, 5, 8'h00, 2'd1, P_NONE};
    vecs[1]  = '{"t1_rel3",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 2'd1, P_NONE};
    vecs[2]  = '{"t1_press7", 4'h7, 1'b1, 1'b0, 1'b0, 5, 8'h00, 2'd2, P_NONE};
    vecs[3]  = '{"t1_rel7",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 2'd2, P_NONE};
    vecs[4]  = '{"t1_ok",     4'h0, 1'b0, 1'b1, 1'b0, 2, 8'h37, 2'd0, P_VAL};
    vecs[5]  = '{"t1_relok",  4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd0, P_NONE};
    vecs[6]  = '{"t2_press5", 4'h5, 1'b1, 1'b0, 1'b0, 3, 8'h37, 2'd1, P_NONE};
    vecs[7]  = '{"t2_rel5",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd1, P_NONE};
    vecs[8]  = '{"t2_ok",     4'h0, 1'b0, 1'b1, 1'b0, 1, 8'h37, 2'd0, P_ERR};
    vecs[9]  = '{"t2_relok",  4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd0, P_NONE};
    vecs[10] = '{"t3_press1", 4'h1, 1'b1, 1'b0, 1'b0, 2, 8'h37, 2'd1, P_NONE};
    vecs[11] = '{"t3_rel1",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd1, P_NONE};
    vecs[12] = '{"t3_pressB", 4'hB, 1'b1, 1'b0, 1'b0, 2, 8'h37, 2'd1, P_NONE};
    vecs[13] = '{"t3_relB",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd1, P_NONE};
    vecs[14] = '{"t3_press2", 4'h2, 1'b1, 1'b0, 1'b0, 2, 8'h37, 2'd2, P_NONE};
    vecs[15] = '{"t3_rel2",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd2, P_NONE};
    vecs[16] = '{"t3_press9", 4'h9, 1'b1, 1'b0, 1'b0, 2, 8'h37, 2'd2, P_NONE};
    vecs[17] = '{"t3_rel9",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h37, 2'd2, P_NONE};
    vecs[18] = '{"t3_ok",     4'h0, 1'b0, 1'b1, 1'b0, 1, 8'h12, 2'd0, P_VAL};
    vecs[19] = '{"t3_relok",  4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h12, 2'd0, P_NONE};
    vecs[20] = '{"ok_empty",  4'h0, 1'b0, 1'b1, 1'b0, 1, 8'h12, 2'd0, P_ERR};
    vecs[21] = '{"ok_e_rel",  4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h12, 2'd0, P_NONE};
    vecs[22] = '{"t4_press4", 4'h4, 1'b1, 1'b0, 1'b0, 2, 8'h12, 2'd1, P_NONE};
    vecs[23] = '{"t4_rel4",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h12, 2'd1, P_NONE};
    vecs[24] = '{"t4_clr_ok", 4'h0, 1'b0, 1'b1, 1'b1, 1, 8'h12, 2'd0, P_NONE};
    vecs[25] = '{"t4_rel",    4'h0, 1'b0, 1'b0, 1'b0, 2, 8'h12, 2'd0, P_NONE};
    vecs[26] = '{"pr_press8", 4'h8, 1'b1, 1'b0, 1'b0, 1, 8'h12, 2'd1, P_NONE};
    vecs[27] = '{"pr_rel8",   4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h12, 2'd1, P_NONE};
    vecs[28] = '{"pr_dig_ok", 4'h5, 1'b1, 1'b1, 1'b0, 1, 8'h12, 2'd0, P_ERR};
    vecs[29] = '{"pr_rel",    4'h0, 1'b0, 1'b0, 1'b0, 1, 8'h12, 2'd0, P_NONE};

    // Reset state.
    rst_n           = 1'b0;
    bus.tecla       = '0;
    bus.tecla_press = 1'b0;
    bus.tecla_ok    = 1'b0;
    bus.tecla_limpa = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.senha",  32'(bus.senha_digitada),  32'h0);
    check("rst.n",      32'(bus.n_digitos),       32'h0);
    check("rst.valida", 32'(bus.senha_valida),    32'h0);
    check("rst.erro",   32'(bus.erro_incompleto), 32'h0);
    check("rst.to",     32'(bus.timeout),         32'h0);
    rst_n = 1'b1;

    // Table-driven main function and same-cycle priority cases.
    for (int i = 0; i < NV; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        drive(vecs[i].name, vecs[i].tecla, vecs[i].press, vecs[i].ok, vecs[i].limpa,
              vecs[i].senha, vecs[i].n, (r == 0) ? vecs[i].pulse : P_NONE);
      end
    end

`ifdef TIMEOUT_EN
    // Digit, then 19 idle cycles: the 19th raises the timeout and clears.
    drive("to_press6", 4'h6, 1'b1, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    for (int c = 1; c < 19; c++) begin
      drive("to_wait", 4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    end
    drive("to_fire",  4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd0, P_TO);
    drive("to_after", 4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd0, P_NONE);
    // Same, but a digit lands on the timeout cycle: digit wins.
    drive("tod_press6", 4'h6, 1'b1, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    for (int c = 1; c < 19; c++) begin
      drive("tod_wait", 4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    end
    drive("tod_press2", 4'h2, 1'b1, 1'b0, 1'b0, 8'h12, 2'd2, P_NONE);
    drive("tod_after",  4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd2, P_NONE);
    drive("tod_clear",  4'h0, 1'b0, 1'b0, 1'b1, 8'h12, 2'd0, P_NONE);
    drive("tod_rel",    4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd0, P_NONE);
`else
    // No timeout: a partial entry persists for 100 cycles.
    drive("nto_press6", 4'h6, 1'b1, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    for (int c = 0; c < 100; c++) begin
      drive("nto_wait", 4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    end
    drive("nto_clear", 4'h0, 1'b0, 1'b0, 1'b1, 8'h12, 2'd0, P_NONE);
    drive("nto_rel",   4'h0, 1'b0, 1'b0, 1'b0, 8'h12, 2'd0, P_NONE);
`endif

    // Asynchronous reset mid-entry clears everything before the next edge.
    drive("ar_press1", 4'h1, 1'b1, 1'b0, 1'b0, 8'h12, 2'd1, P_NONE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.senha",  32'(bus.senha_digitada),  32'h0);
    check("arst.n",      32'(bus.n_digitos),       32'h0);
    check("arst.valida", 32'(bus.senha_valida),    32'h0);
    check("arst.erro",   32'(bus.erro_incompleto), 32'h0);
    check("arst.to",     32'(bus.timeout),         32'h0);
    bus.tecla_press = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive("ar_after", 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, P_NONE);
    // Entry after reset starts from an empty buffer.
    drive("ar_press4", 4'h4, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1, P_NONE);
    drive("ar_rel4",   4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, P_NONE);
    drive("ar_press2", 4'h2, 1'b1, 1'b0, 1'b0, 8'h00, 2'd2, P_NONE);
    drive("ar_rel2",   4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, P_NONE);
    drive("ar_ok",     4'h0, 1'b0, 1'b1, 1'b0, 8'h42, 2'd0, P_VAL);
    drive("ar_relok",  4'h0, 1'b0, 1'b0, 1'b0, 8'h42, 2'd0, P_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
